// File: rtl/ext_pkg.sv
// Shared definitions for the extension pipeline: operation encodings,
// operation-select width and small extension helpers.
package ext_pkg;

  localparam int EXT_OP_W = 3;

  localparam logic [EXT_OP_W-1:0] EXT_ZERO = 3'b000;
  localparam logic [EXT_OP_W-1:0] EXT_SIGN = 3'b001;
  localparam logic [EXT_OP_W-1:0] EXT_LUI  = 3'b010;
  localparam logic [EXT_OP_W-1:0] EXT_LB   = 3'b011;
  localparam logic [EXT_OP_W-1:0] EXT_LBU  = 3'b100;
  localparam logic [EXT_OP_W-1:0] EXT_LH   = 3'b101;
  localparam logic [EXT_OP_W-1:0] EXT_LHU  = 3'b110;
  localparam logic [EXT_OP_W-1:0] EXT_LW   = 3'b111;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] zext8(input logic [7:0] b);
    return {24'h000000, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] h);
    return {16'h0000, h};
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational select/extend logic feeding the first pipeline stage.
// Optional misalignment detection is enabled by defining EXT_PIPE_MISALIGN_EN;
// without it err is constant 0 and loads use only the address bits they need.
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_WIDTH = 16
) (
  input  logic [EXT_OP_W-1:0] ext_op,
  input  logic [31:0]         din,
  input  logic [1:0]          addr,
  output logic [31:0]         dout,
  output logic                err
);

  // Ones in the immediate field, zeros above it.
  localparam logic [31:0] IMM_MASK = (32'h1 << IMM_WIDTH) - 32'h1;

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] zimm_s;
  logic [31:0] result_s;

  // Little-endian byte/halfword lane selection and immediate masking.
  always_comb begin
    case (addr)
      2'd0:    byte_s = din[7:0];
      2'd1:    byte_s = din[15:8];
      2'd2:    byte_s = din[23:16];
      2'd3:    byte_s = din[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr[1] ? din[31:16] : din[15:0];
    zimm_s = din & IMM_MASK;
  end

  // Extension result for the selected operation.
  always_comb begin
    case (ext_op)
      EXT_ZERO: result_s = zimm_s;
      EXT_SIGN: result_s = din[IMM_WIDTH-1] ? (zimm_s | ~IMM_MASK) : zimm_s;
      EXT_LUI:  result_s = {din[15:0], 16'h0000};
      EXT_LB:   result_s = sext8(byte_s);
      EXT_LBU:  result_s = zext8(byte_s);
      EXT_LH:   result_s = sext16(half_s);
      EXT_LHU:  result_s = zext16(half_s);
      EXT_LW:   result_s = din;
      default:  result_s = 32'h0000_0000;
    endcase
  end

`ifdef EXT_PIPE_MISALIGN_EN
  logic mis_s;

  // Halfword loads need an even address, word loads a word-aligned one;
  // a misaligned request still flows through with a zero result.
  always_comb begin
    case (ext_op)
      EXT_LH, EXT_LHU: mis_s = addr[0];
      EXT_LW:          mis_s = (addr != 2'b00);
      default:         mis_s = 1'b0;
    endcase
    if (mis_s) begin
      dout = 32'h0000_0000;
      err  = 1'b1;
    end else begin
      dout = result_s;
      err  = 1'b0;
    end
  end
`else
  assign dout = result_s;
  assign err  = 1'b0;
`endif

endmodule

// File: rtl/ext_pipe.sv
// Pipelined extension unit: ext_core result registered through STAGES stage
// registers behind a valid/ready handshake with a global stall.
// Optional feature macro: EXT_PIPE_MISALIGN_EN (misalignment err flag).
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IMM_WIDTH = 16,
  parameter int STAGES    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXT_OP_W-1:0] extOp,
  input  logic [31:0]         din,
  input  logic [1:0]          addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         dout,
  output logic                err
);

  logic [31:0] core_dout;
  logic        core_err;

  logic [STAGES-1:0]       valid_q, valid_d;
  logic [STAGES-1:0][31:0] dout_q,  dout_d;
  logic [STAGES-1:0]       err_q,   err_d;
  logic                    stall_s;

  ext_core #(.IMM_WIDTH(IMM_WIDTH)) u_core (
    .ext_op (extOp),
    .din    (din),
    .addr   (addr),
    .dout   (core_dout),
    .err    (core_err)
  );

  // The whole pipe freezes when the last stage holds an unconsumed result.
  assign stall_s   = valid_q[STAGES-1] && !out_ready;
  assign in_ready  = !stall_s;
  assign out_valid = valid_q[STAGES-1];
  assign dout      = dout_q[STAGES-1];
  assign err       = err_q[STAGES-1];

  // Next-state for all stages: shift forward when free, hold when stalled.
  // Bubbles carry a zero payload so idle outputs stay deterministic.
  always_comb begin
    valid_d = valid_q;
    dout_d  = dout_q;
    err_d   = err_q;
    if (!stall_s) begin
      valid_d[0] = in_valid;
      dout_d[0]  = in_valid ? core_dout : 32'h0000_0000;
      err_d[0]   = in_valid & core_err;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        dout_d[i]  = dout_q[i-1];
        err_d[i]   = err_q[i-1];
      end
    end else begin
      valid_d = valid_q;
      dout_d  = dout_q;
      err_d   = err_q;
    end
  end

  // Stage registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dout_q  <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: table-driven extension vectors on a
// single-stage instance, plus stall, throughput and reset sequences on
// deeper instances.
module tb_ext_pipe;
  import ext_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance a: STAGES=1
  logic a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic [2:0] a_op = 3'b000; logic [31:0] a_din = 32'h0; logic [1:0] a_addr = 2'b00;
  logic a_in_ready, a_out_valid, a_err; logic [31:0] a_dout;
  // Instance b: STAGES=3
  logic b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [2:0] b_op = 3'b111; logic [31:0] b_din = 32'h0; logic [1:0] b_addr = 2'b00;
  logic b_in_ready, b_out_valid, b_err; logic [31:0] b_dout;
  // Instance c: STAGES=2
  logic c_in_valid = 1'b0, c_out_ready = 1'b1;
  logic [2:0] c_op = 3'b111; logic [31:0] c_din = 32'h0; logic [1:0] c_addr = 2'b00;
  logic c_in_ready, c_out_valid, c_err; logic [31:0] c_dout;

  ext_pipe #(.IMM_WIDTH(16), .STAGES(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .extOp(a_op),
    .din(a_din), .addr(a_addr), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .dout(a_dout), .err(a_err));
  ext_pipe #(.IMM_WIDTH(16), .STAGES(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .extOp(b_op),
    .din(b_din), .addr(b_addr), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .dout(b_dout), .err(b_err));
  ext_pipe #(.IMM_WIDTH(16), .STAGES(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .extOp(c_op),
    .din(c_din), .addr(c_addr), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .dout(c_dout), .err(c_err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] din;
    logic [1:0]  addr;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] held;
    logic        was_stalled;
    int sent, recv;
    logic [31:0] exp_q[$];

    // Vector table (din 80FF7F01: byte0=01 byte1=7F byte2=FF byte3=80)
    vecs[0]  = '{3'b001, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0};
    vecs[1]  = '{3'b000, 32'h0000_8001, 2'd0, 32'h0000_8001, 1'b0};
    vecs[2]  = '{3'b010, 32'h0000_8001, 2'd0, 32'h8001_0000, 1'b0};
    vecs[3]  = '{3'b011, 32'h80FF_7F01, 2'd2, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'h80FF_7F01, 2'd2, 32'h0000_00FF, 1'b0};
    vecs[5]  = '{3'b011, 32'h80FF_7F01, 2'd1, 32'h0000_007F, 1'b0};
    vecs[6]  = '{3'b101, 32'h80FF_7F01, 2'd2, 32'hFFFF_80FF, 1'b0};
    vecs[7]  = '{3'b110, 32'h80FF_7F01, 2'd0, 32'h0000_7F01, 1'b0};
    vecs[8]  = '{3'b011, 32'h80FF_7F01, 2'd3, 32'hFFFF_FF80, 1'b0};
    vecs[9]  = '{3'b110, 32'h80FF_7F01, 2'd2, 32'h0000_80FF, 1'b0};
    vecs[10] = '{3'b111, 32'h80FF_7F01, 2'd0, 32'h80FF_7F01, 1'b0};
    vecs[11] = '{3'b001, 32'h1234_7FFF, 2'd3, 32'h0000_7FFF, 1'b0};
    vecs[12] = '{3'b000, 32'hFFFF_1234, 2'd1, 32'h0000_1234, 1'b0};
    vecs[13] = '{3'b010, 32'hFFFF_1234, 2'd2, 32'h1234_0000, 1'b0};
`ifdef EXT_PIPE_MISALIGN_EN
    vecs[14] = '{3'b111, 32'h80FF_7F01, 2'd1, 32'h0000_0000, 1'b1};
    vecs[15] = '{3'b101, 32'h80FF_7F01, 2'd3, 32'h0000_0000, 1'b1};
`else
    vecs[14] = '{3'b111, 32'h80FF_7F01, 2'd1, 32'h80FF_7F01, 1'b0};
    vecs[15] = '{3'b101, 32'h80FF_7F01, 2'd3, 32'hFFFF_80FF, 1'b0};
`endif

    // Reset state
    #1;
    check("rst_a_out_valid", {31'h0, a_out_valid}, 32'h0);
    check("rst_a_dout", a_dout, 32'h0);
    check("rst_a_err", {31'h0, a_err}, 32'h0);
    check("rst_b_out_valid", {31'h0, b_out_valid}, 32'h0);
    check("rst_c_dout", c_dout, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_a_in_ready", {31'h0, a_in_ready}, 32'h1);
    check("rst_b_in_ready", {31'h0, b_in_ready}, 32'h1);

    // Table vectors on STAGES=1: result visible one edge after acceptance
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_op = vecs[i].op; a_din = vecs[i].din; a_addr = vecs[i].addr;
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), {31'h0, a_out_valid}, 32'h1);
      check($sformatf("vec%0d_dout", i), a_dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_err", i), {31'h0, a_err}, {31'h0, vecs[i].exp_err});
    end
    @(negedge clk); a_in_valid = 1'b0;
    @(posedge clk); #1;
    check("a_bubble_valid", {31'h0, a_out_valid}, 32'h0);

    // Stall on STAGES=3: 5 requests, out_ready low for cycles 4..7
    sent = 0; recv = 0; was_stalled = 1'b0; held = 32'h0;
    for (int k = 0; k < 5; k++) exp_q.push_back(32'hA000_0000 + k);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      b_out_ready = !(cyc >= 4 && cyc < 8);
      b_in_valid  = (sent < 5);
      b_op = EXT_LW; b_addr = 2'b00;
      b_din = 32'hA000_0000 + sent;
      #1;
      if (was_stalled) check("stall_dout_stable", b_dout, held);
      if (b_out_valid && !b_out_ready) begin
        check("stall_in_ready", {31'h0, b_in_ready}, 32'h0);
        was_stalled = 1'b1; held = b_dout;
      end else begin
        was_stalled = 1'b0;
      end
      if (b_out_valid && b_out_ready) begin
        if (exp_q.size() == 0) begin
          check("stall_extra_result", b_dout, 32'hFFFF_FFFF);
        end else begin
          check($sformatf("stall_res%0d", recv), b_dout, exp_q.pop_front());
        end
        recv++;
      end
      if (b_in_valid && b_in_ready) begin
        @(posedge clk);
        sent++;
      end
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    check("stall_sent", sent, 32'd5);
    check("stall_recv", recv, 32'd5);

    // Throughput/latency on STAGES=3: 10 back-to-back, out_ready=1
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      b_in_valid = (k < 10);
      b_din = 32'hC000_0000 + k;
      @(posedge clk); #1;
      check($sformatf("tp_valid%0d", k), {31'h0, b_out_valid}, {31'h0, (k >= 2 && k <= 11)});
      if (k >= 2 && k <= 11) check($sformatf("tp_dout%0d", k), b_dout, 32'hC000_0000 + k - 2);
    end

    // Reset mid-flight on STAGES=2
    @(negedge clk);
    c_in_valid = 1'b1; c_din = 32'hD000_0001;
    @(negedge clk);
    c_din = 32'hD000_0002;
    @(negedge clk);
    c_in_valid = 1'b0;
    #1;
    check("c_pre_rst_valid", {31'h0, c_out_valid}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("c_rst_valid", {31'h0, c_out_valid}, 32'h0);
    check("c_rst_dout", c_dout, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("c_post_rst_valid%0d", k), {31'h0, c_out_valid}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Pipelined, parameterised extension unit for the datapath. It handles immediate zero/sign extension, LUI shifting, and load-data byte/halfword selection with extension, all behind a valid/ready handshake. It sits between the memory/immediate sources and the ALU/register-file write-back mux. It replaces purely combinational extension wherever a registered, stallable result is needed.

## Interface
Parameters:
- IMM_WIDTH, 16, width of the immediate field taken from din[IMM_WIDTH-1:0]; legal 1..31
- STAGES, 1, pipeline register stages between input and output; legal 1..4

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted this cycle when in_valid && in_ready
- extOp  in  3  operation select (encoding below)
- din  in  32  immediate (low IMM_WIDTH bits) or raw memory word
- addr  in  2  byte offset of load address (addr[1:0]); ignored for immediate ops
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- dout  out  32  extended result
- err  out  1  misalignment flag qualified by out_valid (see Configuration)

## Operation
- extOp encoding:
  - 000: zero-extend imm
  - 001: sign-extend imm (bit IMM_WIDTH-1)
  - 010: LUI, {din[15:0], 16'h0000}
  - 011: LB, signed byte
  - 100: LBU, unsigned byte
  - 101: LH, signed halfword
  - 110: LHU, unsigned halfword
  - 111: LW, pass din
- Little-endian byte selection:
  - Byte k = din[8k+7:8k], with k = addr.
  - Halfword = din[31:16] if addr[1], else din[15:0].
- Result is computed combinationally at the input and captured into stage 0. Stages 1..STAGES-1 shift it forward. Each stage holds {valid, dout, err}.
- Global stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - When not stalled, every stage advances. Stage 0 loads in_valid && in_ready.
  - Bubbles are not collapsed.
- While stalled, all stage registers hold their values. dout and err are held stable.

## Timing
- Reset (async, immediate):
  - All stage valids = 0, so out_valid = 0.
  - dout = 32'h0 and err = 0.
  - in_ready = 1 once reset deasserts.
- Latency: a request accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. it is visible in the cycle after STAGES edges including N.
- Throughput: one result per cycle when out_ready is held high.
- Simultaneous accept and consume: permitted in the same cycle. There is no bubble when out_ready = 1.
- out_ready may be high while out_valid = 0. This has no effect.
- Reset mid-operation: all in-flight requests are discarded and none are emitted after reset.
- in_valid dropped while stalled: no effect. The request was not accepted.

## Configuration
- Macro: EXT_PIPE_MISALIGN_EN.
- Defined:
  - Misalignment is checked: LH/LHU with addr[0] = 1, or LW with addr != 2'b00.
  - A misaligned request still flows through the pipeline, with dout = 32'h0 and err = 1.
- Undefined:
  - err is tied to 0.
  - LH/LHU use addr[1] only. LW ignores addr.
  - No misalignment logic is synthesised.

## Structure
- Package ext_pkg holds:
  - the extOp localparams (EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU, EXT_LW)
  - the 3-bit extOp width
- Sub-module ext_core: combinational select/extend/misalignment logic feeding stage 0.
- ext_pipe contains only the stage registers and the handshake.

## Test plan
- Immediates, STAGES=1: extOp=001, din=16'h8001 → dout=32'hFFFF8001 one cycle later. extOp=000 → 32'h00008001. extOp=010 → 32'h80010000.
- Loads: din=32'h80FF7F01.
  - LB, addr=2 → 32'hFFFFFFFF. LBU, addr=2 → 32'h000000FF.
  - LB, addr=1 → 32'h0000007F.
  - LH, addr=2 → 32'hFFFF80FF. LHU, addr=0 → 32'h00007F01.
- Stall, STAGES=3: stream 5 requests with out_ready low for 4 cycles mid-stream. Results must arrive in order, none lost or duplicated, and dout stays stable while stalled.
- Misalignment: LW with addr=1 and LH with addr=3.
  - With EXT_PIPE_MISALIGN_EN: err=1 and dout=0.
  - Without it: err=0, LW → din, LH → din[31:16] sign-extended.
- Reset: assert rst while 2 results are in flight (STAGES=2). out_valid must drop to 0 immediately, and no stale result may appear after release.
- Full throughput: 10 back-to-back requests with out_ready=1 must produce 10 consecutive out_valid cycles.
